// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops one DATA_WIDTH chunk per frame from the upstream FIFO and sends it as start/data/stop.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef FIFO_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  bit_end;
  logic                  start_frame;
`ifdef FIFO_TX_PARITY_EN
  logic                  parity;
`endif

  assign bit_end     = (clk_cnt == CLK_LAST);
  // The pop and the capture share one edge, so rd must be combinational from IDLE.
  assign start_frame = (state == S_IDLE) && tx_en && !empty && !reset;
  assign rd          = start_frame;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_STOP) && bit_end;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_frame) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef FIFO_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
      S_STOP:  if (bit_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef FIFO_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (state == S_IDLE || bit_end) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      if (state == S_DATA && bit_end) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end

      if (start_frame) begin
        shift <= r_data;
`ifdef FIFO_TX_PARITY_EN
        parity <= ^r_data;
`endif
      end else if (state == S_DATA && bit_end) begin
        shift <= shift >> 1;
      end

      // Line level follows the current state one cycle later.
      case (state)
        S_START:  tx <= 1'b0;
        S_DATA:   tx <= shift[0];
`ifdef FIFO_TX_PARITY_EN
        S_PARITY: tx <= parity;
`endif
        default:  tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: small FIFO model feeds the DUT, a negedge monitor decodes tx against queued frames.
module tb_fifo_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int PERIOD = NBITS * CPB + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_en;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          rd;
  logic          tx;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:15];
  logic [3:0]    head = 4'd0;
  logic [3:0]    tail = 4'd0;

  int          ncmp = 0;
  int          nfail = 0;
  logic [15:0] exp_q[$];
  int          rd_times[$];
  int          cyc = 0;

  int          fpos = -1;
  int          fnum = 0;
  logic [15:0] ebits;
  logic [15:0] gbits;
  logic        stable_ok, busy_ok, done_ok;
  int          stray_db = 0;
  int          stray_rd = 0;

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_en  (tx_en),
    .empty  (empty),
    .r_data (r_data),
    .rd     (rd),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  assign empty  = (head == tail);
  assign r_data = mem[head];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd) head <= head + 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [DW-1:0] d);
    logic [15:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef FIFO_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic [15:0] f);
    mem[tail] = d;
    exp_q.push_back(f);
    tail = tail + 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_exp(d, frame_of(d));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(head == tail && fpos == -1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_complete"}, 32'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fpos(input int target, input int budget);
    int n;
    n = 0;
    while (fpos < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_started", 32'(n < budget), 1);
  endtask

  // Monitor: frame position fpos counts negedges since the rd cycle.
  always @(negedge clk) begin
    int b;
    if (reset) begin
      fpos = -1;
    end else begin
      if (fpos >= 1) begin
        if (busy !== (fpos <= 4 * NBITS)) busy_ok = 1'b0;
        if (done !== (fpos == 4 * NBITS)) done_ok = 1'b0;
      end else if (done !== 1'b0 || busy !== 1'b0) begin
        stray_db++;
      end
      if (fpos >= 2) begin
        b = (fpos - 2) / CPB;
        if ((fpos - 2) % CPB == 0) gbits[b] = tx;
        else if (tx !== gbits[b]) stable_ok = 1'b0;
      end
      if (fpos == 4 * NBITS + 1) begin
        chk($sformatf("frame%0d_bits", fnum), 32'(gbits), 32'(ebits));
        chk($sformatf("frame%0d_bit_stable", fnum), 32'(stable_ok), 1);
        chk($sformatf("frame%0d_busy", fnum), 32'(busy_ok), 1);
        chk($sformatf("frame%0d_done_pulse", fnum), 32'(done_ok), 1);
        fpos = -1;
        fnum++;
      end else if (fpos >= 1) begin
        fpos++;
      end
      if (rd) begin
        rd_times.push_back(cyc);
        if (empty) stray_rd++;
        if (fpos != -1 || exp_q.size() == 0) begin
          stray_rd++;
        end else begin
          ebits     = exp_q.pop_front();
          gbits     = '0;
          stable_ok = 1'b1;
          busy_ok   = 1'b1;
          done_ok   = 1'b1;
          fpos      = 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single frame
    @(posedge clk); #1;
    tx_en = 1'b1;
    push(8'hA5);
    wait_idle("a5", 200);

    // two entries back to back
    rd_times.delete();
    @(posedge clk); #1;
    push(8'h3C);
    push(8'hFF);
    wait_idle("b2b", 300);
    chk("b2b_rd_count", 32'(rd_times.size()), 2);
    n = (rd_times.size() >= 2) ? rd_times[1] - rd_times[0] : -1;
    chk("b2b_rd_spacing", 32'(n), 32'(PERIOD));

    // tx_en dropped mid-frame
    @(posedge clk); #1;
    push(8'h01);
    wait_fpos(3, 50);
    @(posedge clk); #1;
    tx_en = 1'b0;
    n = rd_times.size();
    push(8'h55);
    repeat (100) @(negedge clk);
    chk("dis_no_rd", 32'(rd_times.size() - n), 0);
    chk("dis_pending", 32'(exp_q.size()), 1);
    chk("dis_line_idle", 32'(tx), 1);
    @(posedge clk); #1;
    tx_en = 1'b1;
    wait_idle("dis_resume", 200);

    // reset in the middle of the data bits (all-zero data keeps tx low there)
    @(posedge clk); #1;
    push(8'h00);
    wait_fpos(14, 60);
    @(posedge clk); #1;
    chk("pre_reset_tx", 32'(tx), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd", 32'(rd), 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (20) @(negedge clk) if (tx !== 1'b1 || rd !== 1'b0) bad++;
    chk("post_reset_quiet", 32'(bad), 0);

    // empty throughout
    bad = 0;
    repeat (200) @(negedge clk) if (rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    chk("empty_hold", 32'(bad), 0);

`ifdef FIFO_TX_PARITY_EN
    @(posedge clk); #1;
    push_exp(8'h07, 16'h060E);
    push_exp(8'h03, 16'h0406);
    wait_idle("parity", 300);
`endif

    chk("stray_done_busy", 32'(stray_db), 0);
    chk("stray_rd", 32'(stray_rd), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
